// File: rtl/dma_rd_buffer.sv
// ---------------------------------------------------------------------------
// dma_rd_buffer
//
// Purpose:
//   This is the read-side buffer behind the local-bus DMA decoder.
//   - It collects the 16-bit acquisition sample stream and packs each pair of
//     samples into one 32-bit word. The first sample of a pair becomes the low
//     half.
//   - Packed words are stored in a first-word-fall-through FIFO.
//   - Each active-low read strobe from the decoder returns one word (one beat).
//   - A DMA request is raised once a full burst of words is buffered.
//
// Ports:
//   LCLK     in   1      local-bus clock; all logic runs on the rising edge
//   RST_N    in   1      asynchronous active-low reset
//   clr      in   1      synchronous flush of pointers, packer and sticky flags
//   smp      in   DW     acquisition sample
//   smp_vld  in   1      smp is valid this cycle
//   rd_n     in   1      read strobe, active-low; one cycle is one beat
//   ld       out  2*DW   head word for the local bus (first-word-fall-through)
//   dreq     out  1      DMA request, set when level >= BURST
//   level    out  AW+1   number of words stored, 0..2**AW
//   empty    out  1      level == 0
//   full     out  1      level == 2**AW
//   ovf      out  1      sticky: a packed word was dropped because the FIFO was full
//   udf      out  1      sticky: a read beat arrived while the FIFO was empty
// ---------------------------------------------------------------------------
module dma_rd_buffer #(
    parameter int DW    = 16,
    parameter int AW    = 9,
    parameter int BURST = 64
) (
    input  logic            LCLK,
    input  logic            RST_N,
    input  logic            clr,
    input  logic [DW-1:0]   smp,
    input  logic            smp_vld,
    input  logic            rd_n,
    output logic [2*DW-1:0] ld,
    output logic            dreq,
    output logic [AW:0]     level,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            udf
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] BURST_L = (AW+1)'(BURST);

    logic [2*DW-1:0] r_mem [DEPTH];
    logic [2*DW-1:0] r_memRd;
    logic [AW:0]     r_wrPtr;
    logic [AW:0]     r_rdPtr;
    logic [AW:0]     r_level;
    logic [DW-1:0]   r_lo;
    logic            r_loPend;
    logic            r_ldValid;
    logic            r_dreq;
    logic            r_ovf;
    logic            r_udf;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_udfEvt;
    logic            w_pushAtt;
    logic            w_push;
    logic            w_drop;
    logic [2*DW-1:0] w_word;
    logic [AW:0]     w_rdPtrNext;
    logic [AW:0]     w_levelNext;
    logic [AW:0]     w_keep;

    // Full and empty both compare the pointers. The extra top bit is the wrap
    // bit: equal addresses with different wrap bits mean the FIFO is full.
    assign w_empty   = (r_wrPtr == r_rdPtr);
    assign w_full    = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);

    assign w_pop     = !rd_n && !w_empty;
    assign w_udfEvt  = !rd_n && w_empty;
    assign w_pushAtt = smp_vld && r_loPend;
    assign w_word    = {smp, r_lo};

    // When the FIFO is full, a pop in the same cycle frees the slot that the
    // incoming word is written into.
    assign w_push    = w_pushAtt && (!w_full || w_pop);
    assign w_drop    = w_pushAtt && !w_push;

    assign w_rdPtrNext = r_rdPtr + (AW+1)'(w_pop);

    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - 1'b1;
        end
    end

    // Count of words that were already in the RAM before this edge and are
    // still there after it. When this is zero, the next head word is either
    // missing or is being written on this same edge. In both cases the
    // registered read cannot return it yet, so ld shows 0 for one cycle.
    assign w_keep = r_level - (AW+1)'(w_pop);

    // Simple dual-port RAM: synchronous write, registered read.
    // The read address is the *next* read pointer. This prefetches the
    // following head word during a pop, so back-to-back pops see no bubble.
    always_ff @(posedge LCLK) begin
        if (w_push && !clr) begin
            r_mem[r_wrPtr[AW-1:0]] <= w_word;
        end
        r_memRd <= r_mem[w_rdPtrNext[AW-1:0]];
    end

    always_ff @(posedge LCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_level   <= '0;
            r_lo      <= '0;
            r_loPend  <= 1'b0;
            r_ldValid <= 1'b0;
            r_dreq    <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else if (clr) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_level   <= '0;
            r_lo      <= '0;
            r_loPend  <= 1'b0;
            r_ldValid <= 1'b0;
            r_dreq    <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            // Packer: a valid sample either opens a pair (becomes the low
            // half) or closes one (the word is pushed on this same edge).
            if (smp_vld) begin
                if (r_loPend) begin
                    r_loPend <= 1'b0;
                end else begin
                    r_lo     <= smp;
                    r_loPend <= 1'b1;
                end
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            r_rdPtr   <= w_rdPtrNext;
            r_level   <= w_levelNext;
            r_ldValid <= (w_keep != '0);
            r_dreq    <= (w_levelNext >= BURST_L);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_udfEvt) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ld    = r_ldValid ? r_memRd : '0;
    assign dreq  = r_dreq;
    assign level = r_level;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: tb/tb_dma_rd_buffer.sv
// ---------------------------------------------------------------------------
// tb_dma_rd_buffer
//
// Purpose:
//   Self-checking bench for dma_rd_buffer, built with AW=2 and BURST=4.
//   - Every word that should be accepted is pushed onto an expected queue.
//   - A monitor pops that queue on every read beat that the DUT serves and
//     compares ld against the popped word.
//   - Directed checks cover level, flags and ld after reset, clr, burst,
//     overflow and underflow.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dma_rd_buffer;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int BURST = 4;
    localparam int DEPTH = 4;

    logic            LCLK;
    logic            RST_N;
    logic            clr;
    logic [DW-1:0]   smp;
    logic            smp_vld;
    logic            rd_n;
    logic [2*DW-1:0] ld;
    logic            dreq;
    logic [AW:0]     level;
    logic            empty;
    logic            full;
    logic            ovf;
    logic            udf;

    int total = 0;
    int bad   = 0;
    int popsSeen = 0;

    // Reference model of the FIFO and packer.
    int              mLevel  = 0;
    bit              mLoPend = 0;
    logic [15:0]     mLo     = '0;
    bit              mOvf    = 0;
    bit              mUdf    = 0;
    bit              mValid  = 0;
    logic [31:0]     q[$];

    dma_rd_buffer #(.DW(DW), .AW(AW), .BURST(BURST)) dut (
        .LCLK    (LCLK),
        .RST_N   (RST_N),
        .clr     (clr),
        .smp     (smp),
        .smp_vld (smp_vld),
        .rd_n    (rd_n),
        .ld      (ld),
        .dreq    (dreq),
        .level   (level),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .udf     (udf)
    );

    initial LCLK = 1'b0;
    always #5 LCLK = ~LCLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one cycle of stimulus, then updates the model from the same inputs.
    task automatic applyStimulus(input bit doSmp, input logic [15:0] s, input bit doRd);
        bit          pop;
        bit          pushAtt;
        bit          acc;
        logic [31:0] word;
        smp_vld = doSmp;
        smp     = s;
        rd_n    = !doRd;
        @(posedge LCLK);
        pop     = doRd && (mLevel > 0);
        pushAtt = 0;
        word    = '0;
        if (doRd && mLevel == 0) mUdf = 1;
        if (doSmp) begin
            if (mLoPend) begin
                pushAtt = 1;
                word    = {s, mLo};
                mLoPend = 0;
            end else begin
                mLo     = s;
                mLoPend = 1;
            end
        end
        acc = pushAtt && ((mLevel < DEPTH) || pop);
        if (pushAtt && !acc) mOvf = 1;
        mValid = (mLevel - int'(pop)) > 0;
        mLevel = mLevel + int'(acc) - int'(pop);
        if (acc) q.push_back(word);
        #1;
        smp_vld = 1'b0;
        rd_n    = 1'b1;
    endtask

    task automatic doClr();
        clr = 1'b1;
        @(posedge LCLK);
        mLevel = 0; mLoPend = 0; mOvf = 0; mUdf = 0; mValid = 0;
        q.delete();
        #1;
        clr = 1'b0;
    endtask

    // Monitor: every served read beat must return the oldest expected word.
    always @(negedge LCLK) begin
        if (RST_N && !clr && !rd_n && !empty) begin
            popsSeen++;
            if (q.size() == 0) begin
                checkOutput("pop_unexpected", ld, 32'hxxxx_xxxx);
            end else begin
                checkOutput("pop_data", ld, q.pop_front());
            end
        end
    end

    initial begin
        int sent;
        int cycles;
        int popsStart;
        bit doRd;
        bit doSmp;

        RST_N = 1'b0; clr = 1'b0; smp = '0; smp_vld = 1'b0; rd_n = 1'b1;
        repeat (3) @(posedge LCLK);
        #1;
        checkOutput("rst_ld",    ld, 32'h0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full",  32'(full),  32'd0);
        checkOutput("rst_dreq",  32'(dreq),  32'd0);
        checkOutput("rst_ovf",   32'(ovf),   32'd0);
        checkOutput("rst_udf",   32'(udf),   32'd0);
        RST_N = 1'b1;
        @(posedge LCLK); #1;

        // T1: first packed word appears on ld one cycle after the push.
        applyStimulus(1, 16'h0001, 0);
        applyStimulus(1, 16'h0002, 0);
        checkOutput("t1_empty_after_push", 32'(empty), 32'd0);
        applyStimulus(0, 16'h0, 0);
        checkOutput("t1_level", 32'(level), 32'd1);
        checkOutput("t1_ld",    ld, 32'h0002_0001);
        checkOutput("t1_empty", 32'(empty), 32'd0);

        // T2: dreq rises on the edge of the fourth push and falls after one pop.
        doClr();
        checkOutput("clr_level", 32'(level), 32'd0);
        checkOutput("clr_ld",    ld, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 16'(16'h0010 + i), 0);
            if (i == 5) checkOutput("t2_dreq_at_3", 32'(dreq), 32'd0);
        end
        checkOutput("t2_dreq_at_4",  32'(dreq),  32'd1);
        checkOutput("t2_level_at_4", 32'(level), 32'd4);
        applyStimulus(0, 16'h0, 1);
        checkOutput("t2_dreq_after_pop",  32'(dreq),  32'd0);
        checkOutput("t2_level_after_pop", 32'(level), 32'd3);

        // T3: fifth word is dropped, ovf sets, words 1..4 come out in order.
        doClr();
        for (int i = 0; i < 10; i++) applyStimulus(1, 16'(16'h0020 + i), 0);
        checkOutput("t3_full",  32'(full),  32'd1);
        checkOutput("t3_level", 32'(level), 32'd4);
        checkOutput("t3_ovf",   32'(ovf),   32'd1);
        checkOutput("t3_qsize", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'h0, 1);
        checkOutput("t3_drained_empty", 32'(empty), 32'd1);
        checkOutput("t3_ovf_sticky",    32'(ovf),   32'd1);
        checkOutput("t3_all_popped",    32'(q.size()), 32'd0);

        // T4: when full, a push and a pop in the same cycle both succeed.
        doClr();
        for (int i = 0; i < 9; i++) applyStimulus(1, 16'(16'h0030 + i), 0);
        applyStimulus(1, 16'h0039, 1);
        checkOutput("t4_level", 32'(level), 32'd4);
        checkOutput("t4_full",  32'(full),  32'd1);
        checkOutput("t4_ovf",   32'(ovf),   32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 16'h0, 1);
        checkOutput("t4_all_popped", 32'(q.size()), 32'd0);
        checkOutput("t4_empty",      32'(empty), 32'd1);

        // T5: a read beat while empty sets udf; clr clears it.
        doClr();
        applyStimulus(0, 16'h0, 1);
        checkOutput("t5_udf",   32'(udf),   32'd1);
        checkOutput("t5_ld",    ld, 32'h0);
        checkOutput("t5_level", 32'(level), 32'd0);
        doClr();
        checkOutput("t5_udf_clr", 32'(udf), 32'd0);

        // T6: 1000-sample stream with random gaps and reads, many pointer wraps.
        doClr();
        sent = 0;
        cycles = 0;
        popsStart = popsSeen;
        while (sent < 1000 && cycles < 20000) begin
            doRd  = ($urandom_range(0, 1) == 1) && mValid;
            doSmp = ($urandom_range(0, 2) != 0) && !(mLoPend && mLevel == DEPTH && !doRd);
            applyStimulus(doSmp, 16'(sent), doRd);
            if (doSmp) sent++;
            cycles++;
            checkOutput("t6_level", 32'(level), 32'(mLevel));
            checkOutput("t6_dreq",  32'(dreq),  32'(mLevel >= BURST));
            checkOutput("t6_ovf",   32'(ovf),   32'd0);
        end
        if (cycles >= 20000) checkOutput("t6_stream_timeout", 32'(sent), 32'd1000);
        cycles = 0;
        while (mLevel > 0 && cycles < 100) begin
            applyStimulus(0, 16'h0, mValid);
            cycles++;
        end
        checkOutput("t6_drained_level", 32'(level), 32'd0);
        checkOutput("t6_word_count",    32'(popsSeen - popsStart), 32'd500);
        checkOutput("t6_ovf_end",       32'(ovf), 32'd0);

        // An unpaired sample at clr is discarded and does not corrupt the next pair.
        applyStimulus(1, 16'hDEAD, 0);
        doClr();
        applyStimulus(1, 16'hAAAA, 0);
        applyStimulus(1, 16'hBBBB, 0);
        applyStimulus(0, 16'h0, 0);
        checkOutput("odd_clr_level", 32'(level), 32'd1);
        checkOutput("odd_clr_ld",    ld, 32'hBBBB_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
